// File: rtl/pkt_loader.sv
// Packet ingress loader: streams packets into a circular packet RAM and hands
// one (base, length) descriptor per stored packet to the switch.
module pkt_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 10,
  parameter int MAX_PKT_WORDS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic [ADDR_WIDTH-1:0] pkt_base,
  output logic [ADDR_WIDTH:0]   pkt_len,
  output logic                  pkt_trunc,
  input  logic                  rel_valid,
  input  logic [ADDR_WIDTH:0]   rel_len,
  output logic [15:0]           drop_cnt
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         DEPTH_V = CW'(1 << ADDR_WIDTH);
  localparam logic [CW-1:0]         MAX_V   = CW'(MAX_PKT_WORDS);
  localparam logic [CW-1:0]         CNT_ONE = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DROP = 2'd2,
    S_PEND = 2'd3
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Occupancy update with a simultaneous write and release; never goes below zero.
  function automatic logic [CW-1:0] clamp_used(input logic [CW-1:0] used,
                                               input logic          inc,
                                               input logic [CW-1:0] dec);
    logic signed [CW+1:0] sum;
    sum = $signed({2'b00, used}) + $signed({{(CW+1){1'b0}}, inc})
        - $signed({2'b00, dec});
    return (sum < 0) ? '0 : sum[CW-1:0];
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_wr_ptr;
  logic [CW-1:0]           r_used;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [CW-1:0]           r_cnt;
  logic                    r_trunc;
  logic                    r_pkt_valid;
  logic                    r_wr_en;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic [15:0]             r_drop_cnt;

  logic                    w_accept;
  logic                    w_room;
  logic                    w_hs;
  logic                    w_wr;
  logic                    w_start;
  logic                    w_drop;
  logic                    w_trunc_set;
  logic [CW-1:0]           w_rel;

  assign in_ready = rst && (r_state != S_PEND);
  assign w_accept = in_valid && in_ready;
  // Admission reserves a full maximum-size packet so RECV can never overrun.
  assign w_room   = (DEPTH_V - r_used) >= MAX_V;
  assign w_hs     = r_pkt_valid && pkt_ready;
  assign w_rel    = rel_valid ? rel_len : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_start     = 1'b0;
    w_drop      = 1'b0;
    w_trunc_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_room) begin
            w_drop = 1'b1;
            if (!in_last) w_state_nxt = S_DROP;
          end else begin
            w_wr        = 1'b1;
            w_start     = 1'b1;
            w_state_nxt = in_last ? S_PEND : S_RECV;
          end
        end
      end
      S_RECV: begin
        if (w_accept) begin
          if (r_cnt < MAX_V) w_wr = 1'b1;
          else               w_trunc_set = 1'b1;
          if (in_last) w_state_nxt = S_PEND;
        end
      end
      S_DROP: begin
        if (w_accept && in_last) w_state_nxt = S_IDLE;
      end
      S_PEND: begin
        if (w_hs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_used      <= '0;
      r_base      <= '0;
      r_cnt       <= '0;
      r_trunc     <= 1'b0;
      r_pkt_valid <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wr_en <= w_wr;
      if (w_wr) begin
        r_wr_addr <= r_wr_ptr;
        r_wr_data <= in_data;
        r_wr_ptr  <= r_wr_ptr + PTR_ONE;
      end
      if (w_start) begin
        r_base <= r_wr_ptr;
        r_cnt  <= CNT_ONE;
      end else if (w_wr) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (w_trunc_set) r_trunc <= 1'b1;
      else if (w_hs)   r_trunc <= 1'b0;
      // Valid rises one cycle into PEND, after the final RAM write has landed.
      r_pkt_valid <= (r_state == S_PEND) && !w_hs;
      r_used      <= clamp_used(r_used, w_wr, w_rel);
      if (w_drop) r_drop_cnt <= sat_inc16(r_drop_cnt);
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign pkt_valid = r_pkt_valid;
  assign pkt_base  = r_base;
  assign pkt_len   = r_cnt;
  assign pkt_trunc = r_trunc;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_pkt_loader.sv
// Bench for pkt_loader: randomized packet/release traffic checked against a
// packet-level reference model of the ring buffer, plus directed scenarios.
module tb_pkt_loader;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int MAXW  = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          pkt_valid;
  logic          pkt_ready;
  logic [AW-1:0] pkt_base;
  logic [AW:0]   pkt_len;
  logic          pkt_trunc;
  logic          rel_valid;
  logic [AW:0]   rel_len;
  logic [15:0]   drop_cnt;

  always #5 clk = ~clk;

  pkt_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_PKT_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_base(pkt_base),
    .pkt_len(pkt_len), .pkt_trunc(pkt_trunc),
    .rel_valid(rel_valid), .rel_len(rel_len), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
  } beat_t;

  beat_t beat_q[$];
  int    rel_q[$];
  int    base_log[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (packet-level view of the ring)
  int            m_used = 0, m_ptr = 0, m_drops = 0;
  bit            m_in_pkt = 0, m_admit = 0, m_trunc = 0, m_desc = 0;
  int            m_n = 0, m_base = 0, m_desc_due = 0;
  int            d_base = 0, d_len = 0;
  bit            d_trunc = 0;
  bit            e_wr = 0;
  int            e_addr = 0;
  logic [DW-1:0] e_data = '0;
  int            cyc = 0;

  // Stimulus knobs
  int rst_cnt = 2;
  int p_valid = 100, p_ready = 100, p_rel = 100;
  bit rel_en = 1;
  int rel_now = 0, rel_on_acc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic add_pkt(input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = $urandom;
      b.last = (i == len - 1);
      beat_q.push_back(b);
    end
  endtask

  task automatic cycle();
    bit    acc, hs, wrote, exp_pv;
    int    rl;
    beat_t b;
    @(negedge clk);
    exp_pv = m_desc && (cyc >= m_desc_due);
    check_eq("wr_en", 32'(wr_en), 32'(e_wr));
    if (e_wr && wr_en) begin
      check_eq("wr_addr", 32'(wr_addr), 32'(e_addr));
      check_eq("wr_data", wr_data, e_data);
    end
    check_eq("pkt_valid", 32'(pkt_valid), 32'(exp_pv));
    if (exp_pv && pkt_valid) begin
      check_eq("pkt_base", 32'(pkt_base), 32'(d_base));
      check_eq("pkt_len", 32'(pkt_len), 32'(d_len));
      check_eq("pkt_trunc", 32'(pkt_trunc), 32'(d_trunc));
    end
    check_eq("in_ready", 32'(in_ready), 32'(rst && !m_desc));
    check_eq("drop_cnt", 32'(drop_cnt), 32'(m_drops));
    if (!rst) begin
      check_eq("rst_pkt_base", 32'(pkt_base), 32'd0);
      check_eq("rst_pkt_len", 32'(pkt_len), 32'd0);
      check_eq("rst_pkt_trunc", 32'(pkt_trunc), 32'd0);
      check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
      check_eq("rst_wr_data", wr_data, 32'd0);
    end

    rst = (rst_cnt > 0) ? 1'b0 : 1'b1;
    if (rst_cnt > 0) rst_cnt--;
    if (!rst) begin
      in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      pkt_ready = 1'b0; rel_valid = 1'b0; rel_len = '0;
      m_used = 0; m_ptr = 0; m_drops = 0; m_in_pkt = 0; m_desc = 0; e_wr = 0;
      beat_q.delete(); rel_q.delete(); base_log.delete();
      rel_now = 0; rel_on_acc = 0;
      cyc++;
      return;
    end

    in_valid = (beat_q.size() > 0) && ($urandom_range(99) < p_valid);
    if (beat_q.size() > 0) begin
      in_data = beat_q[0].data;
      in_last = beat_q[0].last;
    end else begin
      in_data = '0;
      in_last = 1'b0;
    end
    pkt_ready = ($urandom_range(99) < p_ready);

    acc   = in_valid && !m_desc;
    hs    = exp_pv && pkt_ready;
    wrote = 0;
    e_wr  = 0;
    rl    = 0;
    if (hs) begin
      m_desc = 0;
      rel_q.push_back(d_len);
      base_log.push_back(d_base);
    end
    if (acc) begin
      b = beat_q.pop_front();
      if (!m_in_pkt) begin
        m_in_pkt = 1;
        m_admit  = (DEPTH - m_used) >= MAXW;
        m_n      = 0;
        m_trunc  = 0;
        m_base   = m_ptr;
        if (!m_admit && m_drops < 65535) m_drops++;
      end
      if (m_admit) begin
        if (m_n < MAXW) begin
          e_wr   = 1;
          e_addr = m_ptr;
          e_data = b.data;
          m_ptr  = (m_ptr + 1) % DEPTH;
          m_n++;
          wrote  = 1;
        end else begin
          m_trunc = 1;
        end
      end
      if (b.last) begin
        m_in_pkt = 0;
        if (m_admit) begin
          m_desc     = 1;
          m_desc_due = cyc + 2;
          d_base     = m_base;
          d_len      = m_n;
          d_trunc    = m_trunc;
        end
      end
    end
    if (rel_now > 0) begin
      rl = rel_now;
      rel_now = 0;
    end else if (acc && rel_on_acc > 0) begin
      rl = rel_on_acc;
      rel_on_acc = 0;
    end else if (rel_en && rel_q.size() > 0 && $urandom_range(99) < p_rel) begin
      rl = rel_q.pop_front();
    end
    rel_valid = (rl > 0);
    rel_len   = (AW+1)'(rl);
    m_used    = m_used + int'(wrote) - rl;
    if (m_used < 0) m_used = 0;
    cyc++;
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while ((beat_q.size() > 0 || m_desc || m_in_pkt) && k < limit) begin
      cycle();
      k++;
    end
    check_eq("drain_bound", 32'(k < limit), 32'd1);
    cycle();
    cycle();
  endtask

  task automatic do_reset();
    rst_cnt = 2;
    repeat (3) cycle();
  endtask

  initial begin
    bit found;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    pkt_ready = 1'b0; rel_valid = 1'b0; rel_len = '0;
    repeat (3) cycle();

    // Single 3-word packet
    rel_en = 0;
    add_pkt(3);
    drain(100);
    check_eq("single_ndesc", 32'(base_log.size()), 32'd1);
    check_eq("single_base", 32'(base_log[0]), 32'd0);

    // Ring wrap with prompt releases: a packet starts at 14 and straddles 15->0
    do_reset();
    rel_en = 1; p_rel = 100;
    add_pkt(3); add_pkt(4); add_pkt(4); add_pkt(3); add_pkt(4); add_pkt(4);
    drain(400);
    found = 0;
    foreach (base_log[i]) if (base_log[i] == 14) found = 1;
    check_eq("wrap_base14", 32'(found), 32'd1);
    check_eq("wrap_drops", 32'(drop_cnt), 32'd0);

    // Truncation, then a normal packet
    do_reset();
    add_pkt(7); add_pkt(2);
    drain(200);
    check_eq("trunc_ndesc", 32'(base_log.size()), 32'd2);

    // Fill without releases: fifth packet dropped, then a release admits the next
    do_reset();
    rel_en = 0;
    repeat (5) add_pkt(4);
    drain(300);
    check_eq("fill_drops", 32'(drop_cnt), 32'd1);
    check_eq("fill_ndesc", 32'(base_log.size()), 32'd4);
    rel_now = 4;
    cycle();
    add_pkt(4);
    drain(100);
    check_eq("refill_ndesc", 32'(base_log.size()), 32'd5);
    check_eq("refill_drops", 32'(drop_cnt), 32'd1);

    // Same-cycle write and release on used=5 leaves used=3: ten 1-word packets fit
    do_reset();
    add_pkt(4); add_pkt(1);
    drain(100);
    rel_on_acc = 3;
    add_pkt(1);
    drain(100);
    repeat (12) add_pkt(1);
    drain(400);
    check_eq("samecyc_drops", 32'(drop_cnt), 32'd2);

    // Oversized release clamps occupancy at zero
    rel_now = 31;
    cycle();
    repeat (5) add_pkt(4);
    drain(300);
    check_eq("clamp_drops", 32'(drop_cnt), 32'd3);

    // Descriptor back-pressure stalls the input
    do_reset();
    rel_en = 1;
    p_ready = 0;
    add_pkt(2); add_pkt(3);
    repeat (16) cycle();
    check_eq("stall_ndesc", 32'(base_log.size()), 32'd0);
    check_eq("stall_beats_left", 32'(beat_q.size()), 32'd3);
    p_ready = 100;
    drain(100);
    check_eq("stall_done_ndesc", 32'(base_log.size()), 32'd2);

    // Reset in the middle of a packet; the next packet lands at base 0
    do_reset();
    add_pkt(5);
    cycle(); cycle();
    p_valid = 0;
    cycle(); cycle();
    do_reset();
    p_valid = 100;
    add_pkt(2);
    drain(100);
    check_eq("midrst_ndesc", 32'(base_log.size()), 32'd1);
    check_eq("midrst_base", 32'(base_log[0]), 32'd0);

    // Randomized traffic
    do_reset();
    rel_en = 1; p_rel = 30; p_valid = 70; p_ready = 60;
    for (int i = 0; i < 80; i++) add_pkt($urandom_range(1, 7));
    drain(20000);
    check_eq("rand_beats_left", 32'(beat_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pkt_loader.md
Name: pkt_loader

Overview:
- Upstream ingress stage for the packet RAM that the switch reads headers from.
- Accepts a word-wide packet stream using valid/ready, writes each packet into the RAM's write port, and treats the RAM as a circular buffer.
- For each complete packet, issues one descriptor (base address, length) to the switch, using a valid/ready handshake.
- Tracks RAM occupancy from release notifications sent by the switch, and drops whole packets when there is no guaranteed room.

Parameters:
DATA_WIDTH, 32, stream word / RAM data width (matches `DATA_WIDTH)
ADDR_WIDTH, 10, RAM word address width; ring depth DEPTH = 2^ADDR_WIDTH
MAX_PKT_WORDS, 64, max stored words per packet; must be <= DEPTH

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-low reset
in_valid  in  1  stream word valid
in_ready  out  1  loader can accept a word
in_data  in  DATA_WIDTH  stream word
in_last  in  1  final word of packet
wr_en  out  1  RAM write strobe
wr_addr  out  ADDR_WIDTH  RAM write address
wr_data  out  DATA_WIDTH  RAM write data
pkt_valid  out  1  descriptor valid
pkt_ready  in  1  switch takes descriptor
pkt_base  out  ADDR_WIDTH  address of packet word 0
pkt_len  out  ADDR_WIDTH+1  stored word count, 1..MAX_PKT_WORDS
pkt_trunc  out  1  packet exceeded MAX_PKT_WORDS; tail discarded
rel_valid  in  1  switch frees a packet's words
rel_len  in  ADDR_WIDTH+1  words freed
drop_cnt  out  16  dropped-packet counter, saturating at 16'hFFFF

Behaviour:
- Reset (rst==0 at a clock edge):
  - State goes to IDLE; wr_ptr = 0 and used = 0.
  - All outputs go to 0, including drop_cnt.
  - A packet in progress is abandoned and nothing is written back.
  - in_ready = 0 during reset.
- A beat is accepted when in_valid && in_ready. The upstream source must hold its data stable while in_ready = 0.
- free = DEPTH - used. used is ADDR_WIDTH+1 bits wide.
- State machine:
  - IDLE: in_ready = 1. On acceptance:
    - If free < MAX_PKT_WORDS, go to DROP. drop_cnt++ (saturating). Nothing is written.
    - Otherwise, write the word at wr_ptr and latch base = wr_ptr, cnt = 1.
    - If in_last is set on this beat, go to PEND; otherwise go to RECV.
  - RECV: in_ready = 1. On acceptance:
    - If cnt < MAX_PKT_WORDS, write the word and increment cnt.
    - Otherwise, discard the word and set trunc.
    - If in_last is set, go to PEND.
  - DROP: in_ready = 1. All beats are discarded. in_last returns to IDLE.
  - PEND: in_ready = 0. pkt_valid = 1 with pkt_base = base, pkt_len = cnt, pkt_trunc = trunc, all held stable. When pkt_valid && pkt_ready, go to IDLE the next cycle and clear trunc.
- Write path:
  - wr_en/wr_addr/wr_data are registered, so a write appears in the cycle after its beat is accepted.
  - wr_ptr increments per written word, modulo DEPTH; it wraps from DEPTH-1 to 0 and a packet may straddle the wrap.
  - used increments per written word.
- Descriptor latency:
  - Last beat accepted in cycle N → the final wr_en occurs in cycle N+1 → pkt_valid first asserts in cycle N+2.
  - This guarantees the RAM holds the whole packet before the switch sees the descriptor.
  - Words after an in_last beat, or after truncation, never generate wr_en.
- Release:
  - On rel_valid, used -= rel_len.
  - If a write and a release occur in the same cycle, used' = used + 1 - rel_len.
  - If the result would be below 0, it clamps to 0.
  - The space check on the first beat uses the registered used value.
- The admission check reserves MAX_PKT_WORDS, so a packet accepted into RECV can never overrun unreleased data.
- One descriptor is outstanding at a time. Back-pressure on pkt_ready stalls the input through in_ready = 0 in PEND.
- drop_cnt counts dropped packets, not words.

Test Plan:
- Single packet, 3 beats D0..D2 (in_last on D2), pkt_ready=1 → wr_en at addrs 0,1,2 on cycles N-1..N+1 with data D0..D2; pkt_valid on cycle N+2 with base=0, len=3, trunc=0; returns to IDLE.
- ADDR_WIDTH=4, MAX_PKT_WORDS=4, with releases of each packet's length after its descriptor → writes wrap 15→0; for the packet that starts at 14, pkt_base=14 and wr_addr sequence is 14,15,0,1.
- 70-beat packet with MAX_PKT_WORDS=64 → exactly 64 wr_en; pkt_len=64, pkt_trunc=1; the next packet's trunc=0.
- No releases, DEPTH=16, MAX=4 → the fourth 4-word packet is accepted, the fifth is dropped with no wr_en; drop_cnt=1; after rel_len=4, the next packet is accepted.
- pkt_ready held 0 for 10 cycles → pkt_valid and fields stable, in_ready=0 throughout; same-cycle write and rel_len=3 on used=5 → used=3.
- rst=0 mid-RECV after 2 beats → outputs 0, wr_ptr=0, used=0, drop_cnt=0; a new packet lands at base 0.
